sdram2chr_loader: RTL and testbench
===================================

SDRAM2CHR_LOADER -- requirements
Module: sdram2chr_loader

Interface
REQ-001 The block SHALL have parameter CHR_BYTES, default 8192, the number of bytes copied per load; legal values are powers of two from 2 to 8192.
REQ-002 The block SHALL have parameter SDRAM_AW, default 23, the SDRAM byte-address width.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle load request.
REQ-006 Port base_addr, input, SDRAM_AW: SDRAM address of the CHR image, sampled when start is accepted.
REQ-007 Port sdram_addr, output, SDRAM_AW: read address.
REQ-008 Port sdram_rd, output, 1: read request.
REQ-009 Port sdram_busy, input, 1: the controller cannot accept a request this cycle.
REQ-010 Port sdram_rd_valid, input, 1: sdram_dout is valid this cycle.
REQ-011 Port sdram_dout, input, 8: read data.
REQ-012 Port blk_mem_we, output, 1: CHR block-memory write enable.
REQ-013 Port blk_mem_addr, output, 13: CHR block-memory write address.
REQ-014 Port blk_mem_din, output, 8: CHR block-memory write data.
REQ-015 Port init_sdram_data, output, 1: CHR memory is fully loaded and may be read by the PPU-side bridge.
REQ-016 Port busy, output, 1: a load is in progress.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, WRITE and DONE; busy SHALL be 1 exactly in REQ, WAIT and WRITE.
REQ-018 In IDLE or DONE, start=1 SHALL do the following: latch base_addr, clear the 13-bit byte counter, clear init_sdram_data, and go to REQ.
REQ-019 In REQ, sdram_rd=1 and sdram_addr=latched base+counter; a cycle with sdram_busy=0 SHALL accept the request and move to WAIT; otherwise the FSM stays in REQ with the address held.
REQ-020 In WAIT, sdram_rd=0; on sdram_rd_valid=1 the FSM SHALL register sdram_dout into blk_mem_din and go to WRITE; sdram_rd_valid outside WAIT SHALL be ignored.
REQ-021 In WRITE, blk_mem_we=1 for exactly one cycle with blk_mem_addr=counter[12:0].
REQ-022 In WRITE, if counter==CHR_BYTES-1 the FSM SHALL go to DONE; otherwise it SHALL increment the counter and go to REQ.
REQ-023 In DONE, init_sdram_data=1 and SHALL stay 1 until reset or the next accepted start.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Minimum throughput SHALL be 3 cycles per byte (REQ, WAIT, WRITE) when sdram_busy=0 and rd_valid arrives the cycle after acceptance.
REQ-026 sdram_addr SHALL be latched base plus zero-extended counter, modulo 2^SDRAM_AW; overflow wraps silently.
REQ-027 blk_mem_we SHALL be 0 in every state except WRITE.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst_n=0 the state SHALL be IDLE and sdram_rd, blk_mem_we, init_sdram_data and busy SHALL be 0.
REQ-030 While rst_n=0, sdram_addr, blk_mem_addr, blk_mem_din and the counter SHALL be 0.
REQ-031 Reset asserted mid-load SHALL abort the load immediately; no partial completion flag is produced.
REQ-032 After reset is released mid-load, the block SHALL need a new start to load.

Structure
REQ-033 The state encoding and the default CHR_BYTES constant SHALL live in the shared project package, for reuse by bus2c02-side logic.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 Scenario 1: base_addr=0x000100, zero-wait SDRAM model returning addr[7:0] ^ 0x5A -> 8192 writes with blk_mem_din[i]=(0x100+i)[7:0]^0x5A at addr i; init_sdram_data rises at cycle 3*8192+1 after start.
REQ-036 Scenario 2: sdram_busy high for 5 cycles on byte 7 -> sdram_rd and sdram_addr=base+7 held for 6 cycles, with no write and no skipped address.
REQ-037 Scenario 3: start pulsed at byte 100 with a different base_addr -> ignored; all addresses follow the original base.
REQ-038 Scenario 4: rst_n low at byte 4000, then high, then idle 20 cycles -> no writes, init_sdram_data=0, busy=0; a new start reloads from byte 0.
REQ-039 Scenario 5: after DONE, start with base 0x7FFFFF and CHR_BYTES=4 -> init_sdram_data drops the next cycle, sdram_addr sequence is 7FFFFF, 000000, 000001, 000002, then DONE.
REQ-040 Scenario 6: sdram_rd_valid pulsed in IDLE and in REQ -> no write occurs and the state is unchanged.

Source files
------------

// File: rtl/sdram2chr_loader_pkg.sv
// Shared CHR loader definitions: FSM encoding and default CHR image size, also used by
// the bus2c02-side logic.
package sdram2chr_loader_pkg;

  localparam int unsigned ChrBytesDefault = 8192;
  localparam int unsigned ChrAddrW        = 13;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone
  } loader_state_e;

endpackage

// File: rtl/sdram2chr_loader.sv
// CHR loader: copies CHR_BYTES bytes from SDRAM into the CHR block memory, one byte per
// REQ/WAIT/WRITE pass, then flags the memory as loaded.
module sdram2chr_loader
  import sdram2chr_loader_pkg::*;
#(
  parameter int unsigned CHR_BYTES = ChrBytesDefault,
  parameter int unsigned SDRAM_AW  = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SDRAM_AW-1:0] base_addr,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_rd,
  input  logic                sdram_busy,
  input  logic                sdram_rd_valid,
  input  logic [7:0]          sdram_dout,
  output logic                blk_mem_we,
  output logic [12:0]         blk_mem_addr,
  output logic [7:0]          blk_mem_din,
  output logic                init_sdram_data,
  output logic                busy
);

  localparam logic [ChrAddrW-1:0] LastByte = ChrAddrW'(CHR_BYTES - 1);

  loader_state_e       state_q;
  logic [ChrAddrW-1:0] cnt_q;
  logic [ChrAddrW-1:0] cnt_inc;
  logic [SDRAM_AW-1:0] base_q;

  assign cnt_inc = cnt_q + ChrAddrW'(1);

  // Every output is set on the edge that enters the state which owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      base_q          <= '0;
      sdram_addr      <= '0;
      sdram_rd        <= 1'b0;
      blk_mem_we      <= 1'b0;
      blk_mem_addr    <= '0;
      blk_mem_din     <= '0;
      init_sdram_data <= 1'b0;
      busy            <= 1'b0;
    end else begin
      blk_mem_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q         <= StReq;
            base_q          <= base_addr;
            cnt_q           <= '0;
            sdram_addr      <= base_addr;
            sdram_rd        <= 1'b1;
            init_sdram_data <= 1'b0;
            busy            <= 1'b1;
          end
        end
        StReq: begin
          if (!sdram_busy) begin
            state_q  <= StWait;
            sdram_rd <= 1'b0;
          end
        end
        StWait: begin
          if (sdram_rd_valid) begin
            state_q      <= StWrite;
            blk_mem_din  <= sdram_dout;
            blk_mem_addr <= cnt_q;
            blk_mem_we   <= 1'b1;
          end
        end
        StWrite: begin
          if (cnt_q == LastByte) begin
            state_q         <= StDone;
            init_sdram_data <= 1'b1;
            busy            <= 1'b0;
          end else begin
            state_q    <= StReq;
            cnt_q      <= cnt_inc;
            // Address arithmetic wraps modulo 2^SDRAM_AW.
            sdram_addr <= base_q + SDRAM_AW'(cnt_inc);
            sdram_rd   <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          sdram_rd <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram2chr_loader.sv
// Bench for sdram2chr_loader: SDRAM model with stalls and latency, scoreboard of accepted
// read addresses and block-memory writes against the expected byte-copy sequence.
module tb_sdram2chr_loader;

  localparam int N  = 8192;
  localparam int NS = 4;
  localparam int AW = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] sdram_addr;
  logic          sdram_rd;
  logic          sdram_busy = 1'b0;
  logic          sdram_rd_valid = 1'b0;
  logic [7:0]    sdram_dout = '0;
  logic          blk_mem_we;
  logic [12:0]   blk_mem_addr;
  logic [7:0]    blk_mem_din;
  logic          init_sdram_data;
  logic          busy;

  // Four-byte instance
  logic          s_start = 1'b0;
  logic [AW-1:0] s_base = '0;
  logic [AW-1:0] s_addr;
  logic          s_rd;
  logic          s_sdram_busy = 1'b0;
  logic          s_rd_valid = 1'b0;
  logic [7:0]    s_dout = '0;
  logic          s_we;
  logic [12:0]   s_blk_addr;
  logic [7:0]    s_blk_din;
  logic          s_init;
  logic          s_busy;

  sdram2chr_loader #(.CHR_BYTES(N), .SDRAM_AW(AW)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .sdram_addr      (sdram_addr),
    .sdram_rd        (sdram_rd),
    .sdram_busy      (sdram_busy),
    .sdram_rd_valid  (sdram_rd_valid),
    .sdram_dout      (sdram_dout),
    .blk_mem_we      (blk_mem_we),
    .blk_mem_addr    (blk_mem_addr),
    .blk_mem_din     (blk_mem_din),
    .init_sdram_data (init_sdram_data),
    .busy            (busy)
  );

  sdram2chr_loader #(.CHR_BYTES(NS), .SDRAM_AW(AW)) u_dut_small (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (s_start),
    .base_addr       (s_base),
    .sdram_addr      (s_addr),
    .sdram_rd        (s_rd),
    .sdram_busy      (s_sdram_busy),
    .sdram_rd_valid  (s_rd_valid),
    .sdram_dout      (s_dout),
    .blk_mem_we      (s_we),
    .blk_mem_addr    (s_blk_addr),
    .blk_mem_din     (s_blk_din),
    .init_sdram_data (s_init),
    .busy            (s_busy)
  );

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  int vectors = 0;
  int miscompares = 0;

  // SDRAM model controls and observations
  bit            rand_busy = 1'b0;
  bit            rand_lat = 1'b0;
  bit            stray_valid = 1'b0;
  bit            hold_armed = 1'b0;
  int            hold_left = 0;
  logic [AW-1:0] hold_addr = '0;
  int            held_cycles = 0;
  bit            pend = 1'b0;
  int            lat_left = 0;
  logic [AW-1:0] paddr = '0;
  logic [AW-1:0] aq[$];
  logic [20:0]   wq[$];

  bit            s_pend = 1'b0;
  logic [AW-1:0] s_paddr = '0;
  logic [AW-1:0] s_aq[$];
  logic [20:0]   s_wq[$];

  // Main SDRAM model: inputs change on the falling edge, DUT samples on the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend           = 1'b0;
      hold_left      = 0;
      sdram_busy     = 1'b0;
      sdram_rd_valid = 1'b0;
    end else begin
      if (hold_left > 0) begin
        sdram_busy = 1'b1;
        hold_left--;
      end else if (hold_armed && sdram_rd && sdram_addr == hold_addr) begin
        sdram_busy = 1'b1;
        hold_left  = 4;
        hold_armed = 1'b0;
      end else begin
        sdram_busy = rand_busy && ($urandom_range(7) == 0);
      end
      sdram_rd_valid = stray_valid;
      sdram_dout     = 8'hEE;
      if (pend) begin
        if (lat_left == 0) begin
          sdram_rd_valid = 1'b1;
          sdram_dout     = mem_byte(paddr);
          pend           = 1'b0;
        end else begin
          lat_left--;
        end
      end
      if (sdram_rd && !sdram_busy) begin
        pend     = 1'b1;
        lat_left = rand_lat ? int'($urandom_range(1)) : 0;
        paddr    = sdram_addr;
        aq.push_back(sdram_addr);
      end
      if (sdram_rd && sdram_addr == hold_addr) held_cycles++;
    end
    if (blk_mem_we) wq.push_back({blk_mem_addr, blk_mem_din});
  end

  // Zero-wait model for the small instance
  always @(negedge clk) begin
    s_rd_valid = s_pend && rst_n;
    s_dout     = mem_byte(s_paddr);
    s_pend     = rst_n && s_rd;
    s_paddr    = s_addr;
    if (rst_n && s_rd) s_aq.push_back(s_addr);
    if (s_we) s_wq.push_back({s_blk_addr, s_blk_din});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected load: read i at base+i (wrapping), write i carries the byte stored there.
  task automatic check_load(input string tag, input logic [AW-1:0] b, input int n,
                            input logic [AW-1:0] rq[$], input logic [20:0] wrq[$]);
    int            bad_r;
    int            bad_w;
    logic [AW-1:0] a;
    bad_r = 0;
    bad_w = 0;
    check({tag, " read count"}, rq.size(), n);
    check({tag, " write count"}, wrq.size(), n);
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      if (i >= rq.size() || rq[i] !== a) bad_r++;
      if (i >= wrq.size() || wrq[i] !== {13'(i), mem_byte(a)}) bad_w++;
    end
    check({tag, " bad read addrs"}, bad_r, 0);
    check({tag, " bad writes"}, bad_w, 0);
  endtask

  task automatic run_small(input string tag, input logic [AW-1:0] b);
    int cyc;
    s_aq.delete();
    s_wq.delete();
    s_base  = b;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check({tag, " init drops"}, s_init, 0);
    check({tag, " busy"}, s_busy, 1);
    cyc = 1;
    while (!s_init && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, " done cycle"}, cyc, 3 * NS + 1);
    check({tag, " busy after done"}, s_busy, 0);
    check_load(tag, b, NS, s_aq, s_wq);
  endtask

  initial begin
    logic [AW-1:0] b;
    int            cyc;
    int            n0;
    int            a0;

    repeat (3) tick();
    check("rst sdram_rd", sdram_rd, 0);
    check("rst blk_mem_we", blk_mem_we, 0);
    check("rst init", init_sdram_data, 0);
    check("rst busy", busy, 0);
    check("rst sdram_addr", sdram_addr, 0);
    check("rst blk_mem_addr", blk_mem_addr, 0);
    check("rst blk_mem_din", blk_mem_din, 0);
    rst_n = 1'b1;
    tick();

    // Stray read-valid in IDLE
    stray_valid = 1'b1;
    repeat (3) tick();
    stray_valid = 1'b0;
    tick();
    check("idle stray writes", wq.size(), 0);
    check("idle stray busy", busy, 0);
    check("idle stray rd", sdram_rd, 0);

    // Four-byte loads, second one wrapping past the top of SDRAM
    run_small("small rand", AW'($urandom));
    run_small("small wrap", 23'h7FFFFF);

    // Full zero-wait load from 0x100
    aq.delete();
    wq.delete();
    base_addr = 23'h000100;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = '0;
    check("s1 busy", busy, 1);
    cyc = 1;
    while (!init_sdram_data && cyc < 30000) begin
      tick();
      cyc++;
    end
    check("s1 done cycle", cyc, 3 * N + 1);
    check("s1 busy after done", busy, 0);
    check_load("s1", 23'h000100, N, aq, wq);

    // Reset in the middle of a load
    b = AW'($urandom);
    aq.delete();
    wq.delete();
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("s4 init drops", init_sdram_data, 0);
    cyc = 0;
    while (wq.size() < 4000 && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("s4 reached byte 4000", wq.size(), 4000);
    rst_n = 1'b0;
    tick();
    check("s4 rst sdram_rd", sdram_rd, 0);
    check("s4 rst we", blk_mem_we, 0);
    check("s4 rst init", init_sdram_data, 0);
    check("s4 rst busy", busy, 0);
    check("s4 rst sdram_addr", sdram_addr, 0);
    check("s4 rst blk_mem_addr", blk_mem_addr, 0);
    check("s4 rst blk_mem_din", blk_mem_din, 0);
    tick();
    rst_n = 1'b1;
    n0 = wq.size();
    a0 = aq.size();
    repeat (20) tick();
    check("s4 no writes after reset", wq.size(), n0);
    check("s4 no reads after reset", aq.size(), a0);
    check("s4 init after reset", init_sdram_data, 0);
    check("s4 busy after reset", busy, 0);

    // Reload: busy stall on byte 7, stray valid in REQ, ignored start, random timing
    b = AW'($urandom);
    aq.delete();
    wq.delete();
    hold_addr   = b + AW'(7);
    hold_armed  = 1'b1;
    held_cycles = 0;
    base_addr   = b;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    base_addr   = b ^ 23'h2A5A5A;
    cyc = 0;
    while (held_cycles < 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("s2 stall reached", held_cycles >= 2, 1);
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    cyc = 0;
    while (held_cycles < 6 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("s2 no write during stall", wq.size(), 7);
    check("s2 rd during stall", sdram_rd, 1);
    cyc = 0;
    while (wq.size() < 100 && cyc < 2000) begin
      tick();
      cyc++;
    end
    start = 1'b1;
    tick();
    start     = 1'b0;
    rand_busy = 1'b1;
    rand_lat  = 1'b1;
    cyc = 0;
    while (!init_sdram_data && cyc < 60000) begin
      tick();
      cyc++;
    end
    rand_busy = 1'b0;
    rand_lat  = 1'b0;
    check("s2 load finished", init_sdram_data, 1);
    check("s2 busy after done", busy, 0);
    check("s2 held cycles", held_cycles, 6);
    check_load("s2", b, N, aq, wq);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
